// File: rtl/irq_pkg.sv
// irq_pkg
// Constants shared by the interrupt input front end and the interrupt
// controller, so both sides agree on the irq vector width.
//   IRQ_N_DEFAULT        number of interrupt lines
//   IRQ_W                bit width of a line index
//   SYNC_STAGES_DEFAULT  synchroniser depth per line
//   DEBOUNCE_W_DEFAULT   debounce length / counter width
//   POLARITY_DEFAULT     per-line active level (1 = active-high)
package irq_pkg;

    localparam int IRQ_N_DEFAULT       = 4;
    localparam int IRQ_W               = $clog2(IRQ_N_DEFAULT);
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DEBOUNCE_W_DEFAULT  = 4;

    localparam logic [IRQ_N_DEFAULT-1:0] POLARITY_DEFAULT = '1;

endpackage

// File: rtl/irq_input_conditioner_if.sv
// irq_input_conditioner_if
// Signal bundle between software-facing control/raw lines and the
// conditioner.
//   irq_raw       raw asynchronous interrupt lines
//   mask          1 = line masked from irq_out
//   edge_sel      1 = edge (pulse) mode, 0 = level mode
//   debounce_len  consecutive differing cycles required minus one
//   status_clr    write-1-to-clear for irq_status
//   irq_out       registered request to the interrupt controller
//   irq_status    sticky edge-detected flags
// master drives the inputs and observes the outputs; slave is the conditioner.
interface irq_input_conditioner_if
    import irq_pkg::*;
#(
    parameter int N_IRQ      = IRQ_N_DEFAULT,
    parameter int DEBOUNCE_W = DEBOUNCE_W_DEFAULT
);
    logic [N_IRQ-1:0]      irq_raw;
    logic [N_IRQ-1:0]      mask;
    logic [N_IRQ-1:0]      edge_sel;
    logic [DEBOUNCE_W-1:0] debounce_len;
    logic [N_IRQ-1:0]      status_clr;
    logic [N_IRQ-1:0]      irq_out;
    logic [N_IRQ-1:0]      irq_status;

    modport master (
        output irq_raw,
        output mask,
        output edge_sel,
        output debounce_len,
        output status_clr,
        input  irq_out,
        input  irq_status
    );

    modport slave (
        input  irq_raw,
        input  mask,
        input  edge_sel,
        input  debounce_len,
        input  status_clr,
        output irq_out,
        output irq_status
    );
endinterface

// File: rtl/irq_sync_debounce.sv
// irq_sync_debounce
// Single-line synchroniser followed by a debounce filter.
//   clk, rst      clock, asynchronous active-high reset
//   raw           asynchronous input line
//   debounce_len  differing samples required minus one (0 = no filtering)
//   stable        filtered, synchronised line level
// stable follows the synchronised line only after debounce_len+1
// consecutive edges on which the two differ; any agreeing sample in between
// restarts the count.
module irq_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 4,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  raw,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    output logic                  stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEBOUNCE_W-1:0]  cnt;
    logic                   s;

    // Reset to the line's inactive level so release does not look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Equality compare (not >=): if debounce_len is lowered below a running
    // count, the counter wraps before it matches again. Software only
    // changes debounce_len while the lines are quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= RESET_LEVEL;
            cnt    <= '0;
        end else if (s == stable) begin
            cnt <= '0;
        end else if (cnt == debounce_len) begin
            stable <= s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/irq_input_conditioner.sv
// irq_input_conditioner
// Front end for the interrupt controller's irq inputs: synchronises and
// debounces each raw line, normalises polarity, and produces either a level
// request or a single-cycle edge pulse per line, with masking and a sticky
// edge status for software.
//   clk      clock
//   rst      asynchronous, active-high reset
//   irq_bus  slave side of irq_input_conditioner_if (raw lines, mask,
//            edge_sel, debounce_len, status_clr in; irq_out, irq_status out)
module irq_input_conditioner
    import irq_pkg::*;
#(
    parameter int               N_IRQ       = IRQ_N_DEFAULT,
    parameter int               SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int               DEBOUNCE_W  = DEBOUNCE_W_DEFAULT,
    parameter logic [N_IRQ-1:0] POLARITY    = POLARITY_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    irq_input_conditioner_if.slave  irq_bus
);

    logic [N_IRQ-1:0] stable;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] prev_active;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] irq_out_q;
    logic [N_IRQ-1:0] irq_status_q;
    logic [N_IRQ-1:0] req_next;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        irq_sync_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W),
            .RESET_LEVEL (!POLARITY[i])
        ) u_sync_debounce (
            .clk          (clk),
            .rst          (rst),
            .raw          (irq_bus.irq_raw[i]),
            .debounce_len (irq_bus.debounce_len),
            .stable       (stable[i])
        );
    end

    assign active = ~(stable ^ POLARITY);
    assign rise   = active & ~prev_active;

    // Edge detection depends only on the active transition, so toggling
    // edge_sel never produces a pulse by itself. Masked edges are dropped.
    assign req_next = ((irq_bus.edge_sel & rise) | (~irq_bus.edge_sel & active))
                      & ~irq_bus.mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_active  <= '0;
            irq_out_q    <= '0;
            irq_status_q <= '0;
        end else begin
            prev_active  <= active;
            irq_out_q    <= req_next;
            // Set wins over a simultaneous clear; status ignores mask.
            irq_status_q <= (irq_status_q & ~irq_bus.status_clr)
                            | (rise & irq_bus.edge_sel);
        end
    end

    assign irq_bus.irq_out    = irq_out_q;
    assign irq_bus.irq_status = irq_status_q;

endmodule

// File: doc/irq_input_conditioner.md
Name: irq_input_conditioner

Overview:
Front-end stage that feeds the interrupt controller's irq[3:0] inputs. It synchronises asynchronous raw interrupt lines, debounces them, and normalises polarity. Each line is converted to a level or single-cycle edge request, with per-line masking and a sticky edge-status register for software.

Parameters:
N_IRQ, 4, number of interrupt lines (matches controller irq width)
SYNC_STAGES, 2, synchroniser flops per line (>=2)
DEBOUNCE_W, 4, width of debounce_len and per-line debounce counter
POLARITY, 4'b1111, per-line active level (1 = active-high, 0 = active-low); static

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
irq_raw  in  N_IRQ  raw asynchronous interrupt lines
mask  in  N_IRQ  1 = line masked from irq_out
edge_sel  in  N_IRQ  1 = edge (pulse) mode, 0 = level mode
debounce_len  in  DEBOUNCE_W  consecutive differing cycles required minus one; 0 = no filtering
status_clr  in  N_IRQ  write-1-to-clear for irq_status
irq_out  out  N_IRQ  registered request to interrupt controller irq input
irq_status  out  N_IRQ  sticky "edge detected" flags, set regardless of mask

Behaviour:
- Reset (async, rst=1):
  - sync chain and stable[i] <= ~POLARITY[i] (inactive level).
  - Debounce counters <= 0.
  - prev_active <= 0, irq_out <= 0, irq_status <= 0.
- Synchroniser: SYNC_STAGES flops per line; s[i] denotes the last stage.
- Debounce, per line, each clk edge:
  - s==stable: cnt <= 0.
  - s!=stable and cnt==debounce_len: stable <= s, cnt <= 0.
  - s!=stable and cnt<debounce_len: cnt <= cnt+1.
  - Effect: stable follows s after debounce_len+1 consecutive differing edges.
  - A glitch shorter than that resets cnt and never reaches stable.
- debounce_len changed mid-count: the new value applies from the next comparison. If the new value is below cnt, the line updates when cnt==debounce_len is next reached, i.e. after counter wrap at 2^DEBOUNCE_W. This is accepted; software changes debounce_len only with lines quiet.
- active[i] = stable[i] XNOR POLARITY[i]. prev_active[i] <= active[i] every cycle.
- rise[i] = active & ~prev_active.
- irq_out[i] (registered):
  - level mode: <= active & ~mask.
  - edge mode: <= rise & ~mask, a one-cycle pulse.
  - Edges that occur while masked are dropped from irq_out; unmasking later does not replay them.
- irq_status[i]:
  - Set on rise in edge mode.
  - Cleared by status_clr[i].
  - Set and clear in the same cycle: set wins.
- Latency: raw change sampled at edge E → irq_out changes after edge E+SYNC_STAGES+1+debounce_len (E+3 with defaults and debounce_len=0).
- Mode switch:
  - edge_sel change never generates a pulse by itself; detection depends only on the active transition.
  - Level→edge while active: irq_out drops next cycle.
- Level mode, unmasking while active: irq_out asserts on the next edge. Masking: irq_out deasserts on the next edge.
- The downstream controller latches irq into pending, so one edge-mode pulse raises exactly one request.

Decomposition:
- Package irq_pkg:
  - N_IRQ default, IRQ_W index width, default POLARITY/SYNC_STAGES/DEBOUNCE_W constants.
  - Shared with interrupt_controller so irq widths agree.
- One natural sub-module irq_sync_debounce: single-line synchroniser + debounce counter + stable register, parameterised by SYNC_STAGES, DEBOUNCE_W, RESET_LEVEL.
- Top instantiates it N_IRQ times via generate and adds polarity/edge/mask/status logic.

Test Plan:
- Reset with irq_raw=4'b0000, POLARITY=4'b1111 → irq_out=0, irq_status=0. Then irq_raw[2]=1 at edge E, level mode, unmasked, debounce_len=0 → irq_out=4'b0100 after edge E+3, and held until raw falls.
- Edge mode line 0, debounce_len=0, irq_raw[0] held high 10 cycles → irq_out[0] high exactly one cycle at E+3; irq_status[0]=1 until status_clr[0] pulse, then 0 next edge.
- debounce_len=3, line 1: 3-cycle high glitch → irq_out[1] never asserts. 6-cycle high pulse → asserts at E+2+1+3.
- Edge mode line 3 masked, rising edge → irq_out[3] stays 0, irq_status[3]=1. Unmask afterwards → no pulse.
- status_clr[0] asserted on the same edge a new rise sets status → irq_status[0] remains 1.
- Level mode line 2 active, assert rst mid-operation for 1 cycle → all outputs 0 immediately. After release, irq_out[2] re-asserts after SYNC_STAGES+1 edges.
